// File: rtl/ghost_pkg.sv
// Shared ghost definitions: sprite geometry, edge-code bit positions and the
// hit-detector FSM state type.
package ghost_pkg;

  localparam int unsigned GHOST_WIDTH_X  = 64;
  localparam int unsigned GHOST_HEIGHT_Y = 64;

  // Bit positions inside the 4-bit HitEdgeCode
  localparam int unsigned EDGE_LEFT   = 3;
  localparam int unsigned EDGE_TOP    = 2;
  localparam int unsigned EDGE_RIGHT  = 1;
  localparam int unsigned EDGE_BOTTOM = 0;

  typedef enum logic [1:0] {
    HIT_IDLE,
    HIT_ACCUM,
    HIT_PUBLISH
  } hit_state_t;

endpackage

// File: rtl/edge_classifier.sv
// Maps a sprite-relative pixel offset to the sprite edge(s) it lies on.
// Offsets are two's complement; a negative offset classifies as left/top.
module edge_classifier
  import ghost_pkg::*;
#(
  parameter int unsigned WIDTH_X  = GHOST_WIDTH_X,
  parameter int unsigned HEIGHT_Y = GHOST_HEIGHT_Y,
  parameter int unsigned MARGIN   = 4,
  parameter int unsigned OFF_W    = 12
) (
  input  logic [OFF_W-1:0] offX,
  input  logic [OFF_W-1:0] offY,
  output logic [3:0]       edgeCode
);

  localparam logic [OFF_W-1:0] MARGIN_V   = OFF_W'(MARGIN);
  localparam logic [OFF_W-1:0] RIGHT_TH_V = OFF_W'(WIDTH_X - MARGIN);
  localparam logic [OFF_W-1:0] BOTTOM_TH_V = OFF_W'(HEIGHT_Y - MARGIN);

  logic neg_x;
  logic neg_y;

  assign neg_x = offX[OFF_W-1];
  assign neg_y = offY[OFF_W-1];

  // Unsigned compares below are only trusted once the sign bit is clear
  always_comb begin
    edgeCode              = '0;
    edgeCode[EDGE_LEFT]   = neg_x || (offX < MARGIN_V);
    edgeCode[EDGE_TOP]    = neg_y || (offY < MARGIN_V);
    edgeCode[EDGE_RIGHT]  = !neg_x && (offX >= RIGHT_TH_V);
    edgeCode[EDGE_BOTTOM] = !neg_y && (offY >= BOTTOM_TH_V);
  end

endmodule

// File: rtl/ghost_wall_hit_detector.sv
// Per-frame ghost/wall overlap detector: accumulates overlap edge codes and a
// saturating hit count over a frame, publishing them at the next startOfFrame.
module ghost_wall_hit_detector
  import ghost_pkg::*;
#(
  parameter int unsigned OBJECT_WIDTH_X  = GHOST_WIDTH_X,
  parameter int unsigned OBJECT_HEIGHT_Y = GHOST_HEIGHT_Y,
  parameter int unsigned EDGE_MARGIN     = 4,
  parameter int unsigned MIN_HITS        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic        ghostDrawingRequest,
  input  logic        wallDrawingRequest,
  input  logic        stop,
  output logic        collision,
  output logic [3:0]  HitEdgeCode,
  output logic [7:0]  hitCount
);

  localparam logic [7:0] MIN_HITS_V = 8'(MIN_HITS);

  hit_state_t  state;
  hit_state_t  state_nxt;

  logic        hit_s1;
  logic [11:0] offX_s1;
  logic [11:0] offY_s1;
  logic [3:0]  edge_code;

  logic [3:0]  accCode;
  logic [3:0]  acc_code_nxt;
  logic [7:0]  accCount;
  logic [7:0]  acc_count_nxt;
  logic        publish;

  // Stage 1: unsigned pixel minus sign-extended top-left, 12-bit signed result
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_s1  <= 1'b0;
      offX_s1 <= '0;
      offY_s1 <= '0;
    end else begin
      hit_s1  <= ghostDrawingRequest & wallDrawingRequest & ~stop;
      offX_s1 <= {1'b0, pixelX} - {topLeftX[10], topLeftX};
      offY_s1 <= {1'b0, pixelY} - {topLeftY[10], topLeftY};
    end
  end

  edge_classifier #(
    .WIDTH_X  (OBJECT_WIDTH_X),
    .HEIGHT_Y (OBJECT_HEIGHT_Y),
    .MARGIN   (EDGE_MARGIN),
    .OFF_W    (12)
  ) u_edge_classifier (
    .offX     (offX_s1),
    .offY     (offY_s1),
    .edgeCode (edge_code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HIT_IDLE;
      accCode  <= '0;
      accCount <= '0;
    end else begin
      state    <= state_nxt;
      accCode  <= acc_code_nxt;
      accCount <= acc_count_nxt;
    end
  end

  // PUBLISH reloads the accumulators from the live stage-1 hit so the pixel
  // arriving during the publish cycle opens the new frame.
  always_comb begin
    state_nxt     = state;
    acc_code_nxt  = accCode;
    acc_count_nxt = accCount;
    publish       = 1'b0;
    unique case (state)
      HIT_IDLE: begin
        acc_code_nxt  = '0;
        acc_count_nxt = '0;
        if (startOfFrame) state_nxt = HIT_ACCUM;
      end
      HIT_ACCUM: begin
        if (hit_s1) begin
          acc_code_nxt  = accCode | edge_code;
          acc_count_nxt = (accCount == 8'hFF) ? accCount : accCount + 8'd1;
        end
        if (startOfFrame) state_nxt = HIT_PUBLISH;
      end
      HIT_PUBLISH: begin
        publish       = 1'b1;
        acc_code_nxt  = hit_s1 ? edge_code : 4'b0000;
        acc_count_nxt = hit_s1 ? 8'd1 : 8'd0;
        state_nxt     = startOfFrame ? HIT_PUBLISH : HIT_ACCUM;
      end
      default: begin
        state_nxt     = HIT_IDLE;
        acc_code_nxt  = '0;
        acc_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      collision   <= 1'b0;
      HitEdgeCode <= '0;
      hitCount    <= '0;
    end else if (publish) begin
      collision   <= (accCount >= MIN_HITS_V);
      HitEdgeCode <= accCode;
      hitCount    <= accCount;
    end
  end

endmodule

// File: tb/tb_ghost_wall_hit_detector.sv
// Directed self-checking bench for ghost_wall_hit_detector.
module tb_ghost_wall_hit_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        ghostDrawingRequest;
  logic        wallDrawingRequest;
  logic        stop;
  logic        collision;
  logic [3:0]  HitEdgeCode;
  logic [7:0]  hitCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ghost_wall_hit_detector #(
    .OBJECT_WIDTH_X  (64),
    .OBJECT_HEIGHT_Y (64),
    .EDGE_MARGIN     (4),
    .MIN_HITS        (2)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .startOfFrame        (startOfFrame),
    .pixelX              (pixelX),
    .pixelY              (pixelY),
    .topLeftX            (topLeftX),
    .topLeftY            (topLeftY),
    .ghostDrawingRequest (ghostDrawingRequest),
    .wallDrawingRequest  (wallDrawingRequest),
    .stop                (stop),
    .collision           (collision),
    .HitEdgeCode         (HitEdgeCode),
    .hitCount            (hitCount)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic exp_coll,
                           input logic [3:0] exp_code, input logic [7:0] exp_cnt);
    check({tag, ".collision"}, 32'(collision), 32'(exp_coll));
    check({tag, ".code"}, 32'(HitEdgeCode), 32'(exp_code));
    check({tag, ".count"}, 32'(hitCount), 32'(exp_cnt));
  endtask

  // One overlapping pixel for one cycle
  task automatic pix(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    ghostDrawingRequest = 1'b1;
    wallDrawingRequest  = 1'b1;
    step();
    ghostDrawingRequest = 1'b0;
    wallDrawingRequest  = 1'b0;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  task automatic sof_pix(input int x, input int y);
    startOfFrame = 1'b1;
    pix(x, y);
    startOfFrame = 1'b0;
  endtask

  // startOfFrame, then the PUBLISH cycle; outputs are settled afterwards
  task automatic publish();
    sof();
    step();
  endtask

  initial begin
    reset = 1'b1;
    startOfFrame = 1'b0;
    pixelX = '0;
    pixelY = '0;
    topLeftX = 11'd100;
    topLeftY = 11'd100;
    ghostDrawingRequest = 1'b0;
    wallDrawingRequest = 1'b0;
    stop = 1'b0;
    step();
    step();
    check_out("reset", 1'b0, 4'b0000, 8'd0);
    reset = 1'b0;

    // Hits before the first startOfFrame (IDLE) are discarded
    repeat (5) pix(130, 130);
    sof();
    repeat (4) step();
    publish();
    check_out("idle_discard", 1'b0, 4'b0000, 8'd0);

    // Left-edge wall column: 2 columns x 11 rows
    for (int x = 101; x <= 102; x++)
      for (int y = 120; y <= 130; y++)
        pix(x, y);
    publish();
    check_out("left_col", 1'b1, 4'b1000, 8'd22);

    // Top (offY=0) and bottom (offY=63); previous result must hold meanwhile
    pix(130, 100);
    pix(130, 163);
    repeat (3) step();
    check_out("hold", 1'b1, 4'b1000, 8'd22);
    publish();
    check_out("top_bottom", 1'b1, 4'b0101, 8'd2);

    pix(130, 130);
    publish();
    check_out("single", 1'b0, 4'b0000, 8'd1);

    // Offsets just inside the margins are interior
    pix(104, 130);
    pix(159, 130);
    pix(130, 104);
    pix(130, 159);
    publish();
    check_out("margin_inside", 1'b1, 4'b0000, 8'd4);

    // Right at 60, left at 3, negative X and Y offsets, bottom at 60
    pix(160, 130);
    pix(103, 130);
    topLeftX = 11'd150;
    pix(140, 130);
    topLeftX = 11'd100;
    pix(130, 96);
    pix(130, 160);
    publish();
    check_out("margin_edges", 1'b1, 4'b1111, 8'd5);

    // Stage-1 hit during the startOfFrame cycle closes the old frame;
    // the pixel on the inputs in that cycle opens the new one.
    pix(130, 100);
    sof_pix(130, 163);
    step();
    check_out("sof_closing", 1'b0, 4'b0100, 8'd1);
    publish();
    check_out("sof_newframe", 1'b0, 4'b0001, 8'd1);

    repeat (300) pix(130, 130);
    publish();
    check_out("saturate", 1'b1, 4'b0000, 8'd255);

    // Back-to-back startOfFrame
    repeat (3) pix(130, 130);
    sof_pix(130, 100);
    sof();
    check_out("b2b_first", 1'b1, 4'b0000, 8'd3);
    step();
    check_out("b2b_second", 1'b0, 4'b0100, 8'd1);

    // Paused frame publishes nothing
    stop = 1'b1;
    repeat (5) pix(130, 130);
    pix(101, 120);
    publish();
    stop = 1'b0;
    check_out("stop", 1'b0, 4'b0000, 8'd0);

    repeat (10) pix(130, 130);
    publish();
    check_out("ten_hits", 1'b1, 4'b0000, 8'd10);

    // Mid-frame reset, coinciding with startOfFrame: reset wins
    repeat (10) pix(130, 130);
    reset = 1'b1;
    startOfFrame = 1'b1;
    step();
    reset = 1'b0;
    startOfFrame = 1'b0;
    check_out("reset_mid", 1'b0, 4'b0000, 8'd0);
    repeat (5) pix(130, 130);
    publish();
    check_out("reset_partial", 1'b0, 4'b0000, 8'd0);
    pix(130, 130);
    pix(101, 130);
    publish();
    check_out("recover", 1'b1, 4'b1000, 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
